// File: rtl/sd_dat_receive.sv
// SD card data-block receiver: samples DAT[3:0] on rising sd_clk edges, streams bytes out,
// and verifies per-lane CRC16 and the end bit in 1-bit or 4-bit bus mode.
module sd_dat_receive #(
  parameter int BLOCK_BYTES   = 512,
  parameter int TIMEOUT_EDGES = 65535
) (
  input  logic       ex_clk,
  input  logic       reset,
  input  logic       sd_clk,
  input  logic       rx_en,
  input  logic       wide_bus,
  input  logic [3:0] sd_dat_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       busy,
  output logic       done,
  output logic       crc_err,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_START,
    S_DATA,
    S_CRC,
    S_END
  } state_t;

  localparam logic [12:0] LAST_BYTE = 13'(BLOCK_BYTES - 1);
  localparam logic [16:0] TMO_LIMIT = 17'(TIMEOUT_EDGES);

  state_t            state_q, state_d;
  logic              sd_clk_q;
  logic              wide_q, wide_d;
  logic [7:0]        shift_q, shift_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [12:0]       byte_cnt_q, byte_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  logic [3:0][15:0]  crc_q, crc_d;
  logic [7:0]        byte_data_q, byte_data_d;
  logic              byte_valid_q, byte_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              crc_err_q, crc_err_d;
  logic              timeout_err_q, timeout_err_d;

  logic              tick;
  logic [3:0]        lane_mask;
  logic [3:0]        active_dat;
  logic              byte_complete;
  logic              crc_bad;
  logic [16:0]       tmo_next;

  // Shifting the transmitted CRC through the same register leaves a zero residue on a match.
  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  assign tick       = sd_clk & ~sd_clk_q;
  assign lane_mask  = wide_q ? 4'hF : 4'h1;
  assign active_dat = sd_dat_in & lane_mask;
  assign tmo_next   = {1'b0, tmo_cnt_q} + 17'd1;

  always_comb begin
    state_d       = state_q;
    wide_d        = wide_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    crc_d         = crc_q;
    byte_data_d   = byte_data_q;
    byte_valid_d  = 1'b0;
    busy_d        = busy_q;
    done_d        = 1'b0;
    crc_err_d     = crc_err_q;
    timeout_err_d = timeout_err_q;
    byte_complete = 1'b0;
    crc_bad       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_en && !done_q) begin
          state_d       = S_WAIT_START;
          busy_d        = 1'b1;
          wide_d        = wide_bus;
          crc_err_d     = 1'b0;
          timeout_err_d = 1'b0;
          crc_d         = '0;
          bit_cnt_d     = '0;
          byte_cnt_d    = '0;
          tmo_cnt_d     = '0;
        end
      end

      S_WAIT_START: begin
        if (tick) begin
          if (active_dat == 4'h0) begin
            state_d = S_DATA;
          end else begin
            if (tmo_cnt_q != 16'hFFFF) begin
              tmo_cnt_d = tmo_next[15:0];
            end
            if (tmo_next >= TMO_LIMIT) begin
              timeout_err_d = 1'b1;
              done_d        = 1'b1;
              busy_d        = 1'b0;
              state_d       = S_IDLE;
            end
          end
        end
      end

      S_DATA: begin
        if (tick) begin
          for (int l = 0; l < 4; l++) begin
            crc_d[l] = crc16_step(crc_q[l], sd_dat_in[l]);
          end
          if (wide_q) begin
            shift_d       = {shift_q[3:0], sd_dat_in};
            byte_complete = bit_cnt_q[0];
          end else begin
            shift_d       = {shift_q[6:0], sd_dat_in[0]};
            byte_complete = (bit_cnt_q == 3'd7);
          end
          bit_cnt_d = byte_complete ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_complete) begin
            byte_data_d  = shift_d;
            byte_valid_d = 1'b1;
            if (byte_cnt_q == LAST_BYTE) begin
              byte_cnt_d = '0;
              state_d    = S_CRC;
            end else begin
              byte_cnt_d = byte_cnt_q + 13'd1;
            end
          end
        end
      end

      // The byte counter is reused to count the 16 CRC ticks.
      S_CRC: begin
        if (tick) begin
          for (int l = 0; l < 4; l++) begin
            crc_d[l] = crc16_step(crc_q[l], sd_dat_in[l]);
          end
          if (byte_cnt_q == 13'd15) begin
            byte_cnt_d = '0;
            state_d    = S_END;
          end else begin
            byte_cnt_d = byte_cnt_q + 13'd1;
          end
        end
      end

      S_END: begin
        if (tick) begin
          for (int l = 0; l < 4; l++) begin
            if (lane_mask[l] && (crc_q[l] != 16'h0000)) begin
              crc_bad = 1'b1;
            end
          end
          crc_err_d = crc_bad | (active_dat != lane_mask);
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ex_clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sd_clk_q      <= 1'b0;
      wide_q        <= 1'b0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      crc_q         <= '0;
      byte_data_q   <= '0;
      byte_valid_q  <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      crc_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sd_clk_q      <= sd_clk;
      wide_q        <= wide_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      crc_q         <= crc_d;
      byte_data_q   <= byte_data_d;
      byte_valid_q  <= byte_valid_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      crc_err_q     <= crc_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign crc_err     = crc_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sd_dat_receive.sv
// Bench for sd_dat_receive: two instances (512-byte and 4-byte blocks) share the SD pins;
// expected bytes go into a scoreboard queue as they are driven and are popped on byte_valid.
module tb_sd_dat_receive;

  logic       ex_clk = 1'b0;
  logic       reset;
  logic       sd_clk;
  logic       rx_en_big, rx_en_small;
  logic       wide_bus;
  logic [3:0] sd_dat_in;
  logic       sel;

  logic [7:0] bdBig, bdSmall;
  logic       bvBig, bvSmall, busyBig, busySmall, doneBig, doneSmall;
  logic       ceBig, ceSmall, teBig, teSmall;

  logic [7:0] obsData;
  logic       obsValid, obsBusy, obsDone, obsCrcErr, obsTmoErr;

  logic [7:0] txData [0:511];
  logic [7:0] expQ [$];
  int         passCount = 0;
  int         checkCount = 0;

  always #5 ex_clk = ~ex_clk;

  sd_dat_receive #(.BLOCK_BYTES(512), .TIMEOUT_EDGES(16)) dutBig (
    .ex_clk(ex_clk), .reset(reset), .sd_clk(sd_clk), .rx_en(rx_en_big),
    .wide_bus(wide_bus), .sd_dat_in(sd_dat_in), .byte_data(bdBig), .byte_valid(bvBig),
    .busy(busyBig), .done(doneBig), .crc_err(ceBig), .timeout_err(teBig));

  sd_dat_receive #(.BLOCK_BYTES(4), .TIMEOUT_EDGES(16)) dutSmall (
    .ex_clk(ex_clk), .reset(reset), .sd_clk(sd_clk), .rx_en(rx_en_small),
    .wide_bus(wide_bus), .sd_dat_in(sd_dat_in), .byte_data(bdSmall), .byte_valid(bvSmall),
    .busy(busySmall), .done(doneSmall), .crc_err(ceSmall), .timeout_err(teSmall));

  always_comb begin
    obsData   = sel ? bdBig   : bdSmall;
    obsValid  = sel ? bvBig   : bvSmall;
    obsBusy   = sel ? busyBig : busySmall;
    obsDone   = sel ? doneBig : doneSmall;
    obsCrcErr = sel ? ceBig   : ceSmall;
    obsTmoErr = sel ? teBig   : teSmall;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs === exp) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
  endtask

  always @(negedge ex_clk) begin
    if (obsValid === 1'b1) begin
      if (expQ.size() == 0) checkOutput("sb_underflow", expQ.size(), 1);
      else checkOutput("sb_byte", {24'd0, obsData}, {24'd0, expQ.pop_front()});
    end
  end

  function automatic logic [15:0] crcUpd(input logic [15:0] c, input logic b);
    logic [15:0] r;
    r = {c[14:0], 1'b0};
    if (b ^ c[15]) r = r ^ 16'h1021;
    return r;
  endfunction

  // One sd_clk period; checks byte_valid one ex_clk after the rising edge is seen.
  task automatic sdTick(input logic [3:0] dat, input logic expValid, input string tag);
    sd_clk = 1'b0;
    sd_dat_in = dat;
    @(negedge ex_clk);
    @(negedge ex_clk);
    sd_clk = 1'b1;
    @(negedge ex_clk);
    checkOutput(tag, obsValid, expValid);
  endtask

  task automatic startXfer(input logic big, input logic w);
    sel = big;
    wide_bus = w;
    if (big) rx_en_big = 1'b1;
    else rx_en_small = 1'b1;
    @(negedge ex_clk);
    rx_en_big = 1'b0;
    rx_en_small = 1'b0;
    checkOutput("busy_start", obsBusy, 1);
    checkOutput("errs_cleared", {obsCrcErr, obsTmoErr}, 0);
  endtask

  task automatic applyStimulus(input logic big, input logic w, input int nBytes,
                               input int flipLane, input int flipBit, input logic endBad,
                               input logic useFixed, input logic [15:0] fixedCrc,
                               input int resetAfter);
    logic [15:0] mcrc [4];
    logic [3:0]  mask, d;
    logic [7:0]  b;
    logic        expErr;
    mask = w ? 4'hF : 4'h1;
    for (int l = 0; l < 4; l++) mcrc[l] = 16'h0000;
    expErr = (flipLane >= 0) || endBad;
    startXfer(big, w);
    sdTick(4'hF, 1'b0, "idle_valid");
    sdTick(4'hF, 1'b0, "idle_valid");
    sdTick(~mask, 1'b0, "start_valid");
    for (int i = 0; i < nBytes; i++) begin
      b = txData[i];
      expQ.push_back(b);
      if (w) begin
        for (int h = 0; h < 2; h++) begin
          d = (h == 0) ? b[7:4] : b[3:0];
          for (int l = 0; l < 4; l++) mcrc[l] = crcUpd(mcrc[l], d[l]);
          sdTick(d, h == 1, "byte_valid_timing");
        end
      end else begin
        for (int k = 7; k >= 0; k--) begin
          mcrc[0] = crcUpd(mcrc[0], b[k]);
          sdTick({3'b111, b[k]}, k == 0, "byte_valid_timing");
        end
      end
      if (i == resetAfter) begin
        reset = 1'b1;
        @(negedge ex_clk);
        checkOutput("reset_busy", obsBusy, 0);
        checkOutput("reset_valid", obsValid, 0);
        reset = 1'b0;
        expQ.delete();
        for (int t = 0; t < 16; t++) sdTick(4'($urandom_range(0, 15)), 1'b0, "post_reset_valid");
        checkOutput("post_reset_busy", obsBusy, 0);
        return;
      end
    end
    if (useFixed) mcrc[0] = fixedCrc;
    if (flipLane >= 0) mcrc[flipLane][flipBit] = ~mcrc[flipLane][flipBit];
    for (int k = 15; k >= 0; k--) begin
      d = ~mask;
      for (int l = 0; l < 4; l++) if (mask[l]) d[l] = mcrc[l][k];
      sdTick(d, 1'b0, "crc_valid");
    end
    sdTick(endBad ? ~mask : 4'hF, 1'b0, "end_valid");
    checkOutput("done_pulse", obsDone, 1);
    checkOutput("busy_end", obsBusy, 0);
    checkOutput("crc_err", obsCrcErr, expErr);
    checkOutput("timeout_err", obsTmoErr, 0);
    checkOutput("sb_drained", expQ.size(), 0);
    @(negedge ex_clk);
    checkOutput("done_one_cycle", obsDone, 0);
    checkOutput("crc_err_sticky", obsCrcErr, expErr);
  endtask

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    sd_clk = 1'b0;
    rx_en_big = 1'b0;
    rx_en_small = 1'b0;
    wide_bus = 1'b0;
    sd_dat_in = 4'hF;
    sel = 1'b1;
    repeat (3) @(negedge ex_clk);
    checkOutput("rst_byte_data", bdBig, 0);
    checkOutput("rst_byte_valid", bvBig, 0);
    checkOutput("rst_busy", busyBig, 0);
    checkOutput("rst_done", doneBig, 0);
    checkOutput("rst_crc_err", ceBig, 0);
    checkOutput("rst_timeout_err", teBig, 0);
    reset = 1'b0;
    @(negedge ex_clk);

    $display("[TB] 1-bit, 512 x 0xFF, CRC 0x7FA1");
    for (int i = 0; i < 512; i++) txData[i] = 8'hFF;
    applyStimulus(1'b1, 1'b0, 512, -1, 0, 1'b0, 1'b1, 16'h7FA1, -1);

    $display("[TB] 4-bit, 4 bytes, good CRC");
    txData[0] = 8'h12; txData[1] = 8'h34; txData[2] = 8'h56; txData[3] = 8'h78;
    applyStimulus(1'b0, 1'b1, 4, -1, 0, 1'b0, 1'b0, 16'h0, -1);

    $display("[TB] 4-bit, DAT2 CRC bit 5 flipped");
    applyStimulus(1'b0, 1'b1, 4, 2, 5, 1'b0, 1'b0, 16'h0, -1);

    $display("[TB] 1-bit, bad end bit");
    for (int i = 0; i < 4; i++) txData[i] = 8'($urandom_range(0, 255));
    applyStimulus(1'b0, 1'b0, 4, -1, 0, 1'b1, 1'b0, 16'h0, -1);

    $display("[TB] timeout with DAT held high");
    startXfer(1'b0, 1'b0);
    for (int t = 1; t <= 16; t++) begin
      sdTick(4'hF, 1'b0, "tmo_valid");
      if (t == 15) checkOutput("tmo_not_early", obsDone, 0);
    end
    checkOutput("tmo_done", obsDone, 1);
    checkOutput("tmo_err", obsTmoErr, 1);
    checkOutput("tmo_busy", obsBusy, 0);
    checkOutput("tmo_crc_err", obsCrcErr, 0);
    rx_en_small = 1'b1;
    @(negedge ex_clk);
    rx_en_small = 1'b0;
    checkOutput("rx_en_with_done_ignored", obsBusy, 0);
    checkOutput("tmo_sticky", obsTmoErr, 1);
    @(negedge ex_clk);

    $display("[TB] reset after byte 2, then a fresh 4-bit block");
    for (int i = 0; i < 512; i++) txData[i] = 8'($urandom_range(0, 255));
    applyStimulus(1'b1, 1'b0, 512, -1, 0, 1'b0, 1'b0, 16'h0, 1);
    @(negedge ex_clk);
    applyStimulus(1'b1, 1'b1, 512, -1, 0, 1'b0, 1'b0, 16'h0, -1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sd_dat_receive.md
Name: sd_dat_receive

Overview:
- Receives one data block from the SD card on DAT[3:0] and delivers it as a byte stream to sd_fsm and the UART path.
- Supports 1-bit mode (DAT0 only) and 4-bit mode, and checks the per-lane CRC16 and the end bit.
- Runs in the ex_clk domain and samples the divided sd_clk as a plain signal, the same way sd_send and sd_receive do.
- Sits between the sd_dat_pin input and the controller FSM, alongside sd_receive.

Parameters:
- BLOCK_BYTES, 512, data bytes per block (range 1..4096).
- TIMEOUT_EDGES, 65535, number of sd_clk rising edges to wait for the start bit before giving up.

Ports:
- ex_clk  input  1  system clock; the only clock in the block.
- reset  input  1  synchronous, active-high reset; driven as ~ex_resetn | sd_reset.
- sd_clk  input  1  divided SD clock level, sampled on ex_clk.
- rx_en  input  1  one-cycle start request.
- wide_bus  input  1  1 = 4-bit mode, 0 = 1-bit mode; latched when rx_en is accepted.
- sd_dat_in  input  4  DAT[3:0] pin levels.
- byte_data  output  8  received byte.
- byte_valid  output  1  one-cycle strobe; byte_data is valid in the same cycle.
- busy  output  1  high from rx_en acceptance until done.
- done  output  1  one-cycle pulse when the transfer ends (success or error).
- crc_err  output  1  sticky; any lane CRC mismatch or end-bit error.
- timeout_err  output  1  sticky; no start bit within TIMEOUT_EDGES.

Behaviour:
- Reset: state = IDLE. byte_data, byte_valid, busy, done, crc_err and timeout_err all = 0. Edge detector history = 0. Reset has priority over every other event, including a transfer in progress.
- Edge tick: sd_clk_q registers sd_clk each ex_clk cycle; tick = sd_clk & ~sd_clk_q. All DAT sampling and all counters advance only on tick cycles.
- Active lanes: DAT[3:0] when wide_bus is latched 1, DAT0 alone when it is 0.
- IDLE:
  - rx_en = 1 → go to WAIT_START; busy = 1; clear crc_err, timeout_err, the CRC registers and all counters.
  - rx_en while busy is ignored.
- WAIT_START:
  - On a tick with all active lanes = 0 → go to DATA.
  - Otherwise increment the timeout counter. When the count reaches TIMEOUT_EDGES → set timeout_err, pulse done, go to IDLE.
- DATA:
  - 1-bit mode: 8 ticks per byte, MSB first.
  - 4-bit mode: 2 ticks per byte, high nibble first; DAT3 carries the MSB of each nibble.
  - byte_valid pulses for one cycle, in the ex_clk cycle after the tick that completes the byte. byte_data holds its value until the next byte.
  - Each lane's sampled bits feed that lane's own CRC16 register.
  - After BLOCK_BYTES bytes → go to CRC.
- CRC16:
  - Polynomial x^16 + x^12 + x^5 + 1, initial value 0x0000, computed over data bits only, one register per lane.
  - Inactive lanes are ignored.
- CRC state: 16 ticks; each active lane shifts in its received CRC, MSB first. Then go to END.
- END: on the next tick, every active lane must read 1.
  - A failed end-bit check or any CRC mismatch sets crc_err.
  - On the same cycle, pulse done and go to IDLE; busy falls in that cycle.
- Counters:
  - The byte counter is 13 bits, so no wrap occurs for BLOCK_BYTES ≤ 4096.
  - The bit counter is 3 bits and wraps per byte.
  - The timeout counter is 16 bits and saturates.
- Simultaneous events:
  - rx_en with reset → reset wins.
  - rx_en in the same cycle as done → ignored; it is accepted on a later cycle.
- Errors: the received data is still streamed on a CRC error; the consumer must check crc_err at done.

Test Plan:
- 1-bit mode, BLOCK_BYTES=512, start bit, then 512 bytes of 0xFF, CRC 0x7FA1, end bit 1 → 512 byte_valid pulses all carrying 0xFF, then done with crc_err = 0 and timeout_err = 0.
- 4-bit mode, BLOCK_BYTES=4, data bytes 0x12 0x34 0x56 0x78 with correct per-lane CRCs from the bench model → bytes arrive in order 0x12, 0x34, 0x56, 0x78, each one ex_clk after its second nibble tick; done with crc_err = 0.
- Same as the 4-bit case, but with DAT2's CRC bit 5 flipped → all 4 bytes are still delivered; done with crc_err = 1.
- 1-bit mode with end bit forced to 0 and a correct CRC → done with crc_err = 1.
- TIMEOUT_EDGES=16, DAT held high → done on the 16th tick with timeout_err = 1, no byte_valid pulses, busy = 0 afterwards.
- Reset asserted after byte 2 of a transfer → next cycle busy = 0 and no further byte_valid pulses. A new rx_en then completes a fresh block cleanly.
